// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field positions, NOP encoding, PC step
// and the opcode map also used by the decode-stage ControlUnit.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int FUNC_HI = 3;
    localparam int FUNC_LO = 0;
    localparam int PC_STEP = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_ADDI = 4'h2,
        OP_LW   = 4'h3,
        OP_SW   = 4'h4,
        OP_BEQ  = 4'h5,
        OP_BNE  = 4'h6,
        OP_JMP  = 4'h7,
        OP_HALT = 4'hF
    } opcode_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and
// the IF/ID outputs consumed by decode.
interface fetch_stage_if #(
    parameter int PC_W = 16
);
    import cpu_pkg::*;

    logic [PC_W-1:0]    InstrAddr;
    logic [INSTR_W-1:0] InstrData;
    logic               Stall;
    logic               BranchTaken;
    logic [PC_W-1:0]    BranchTarget;
    logic               Jump;
    logic [PC_W-1:0]    JumpTarget;
    logic               HaltIn;
    logic [INSTR_W-1:0] IfIdInstr;
    logic [PC_W-1:0]    IfIdPC;
    logic               IfIdValid;
    logic [3:0]         Opcode;
    logic [3:0]         FunctionCode;
    logic               Halted;

    modport master (
        input  InstrData, Stall, BranchTaken, BranchTarget, Jump, JumpTarget, HaltIn,
        output InstrAddr, IfIdInstr, IfIdPC, IfIdValid, Opcode, FunctionCode, Halted
    );

    modport slave (
        output InstrData, Stall, BranchTaken, BranchTarget, Jump, JumpTarget, HaltIn,
        input  InstrAddr, IfIdInstr, IfIdPC, IfIdValid, Opcode, FunctionCode, Halted
    );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Flush beats hold beats load; a flush keeps the
// old PC field since it is meaningless once Valid drops.
module if_id_register
    import cpu_pkg::*;
#(
    parameter int                 PC_W = 16,
    parameter logic [INSTR_W-1:0] NOP  = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic               hold,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [PC_W-1:0]    fetch_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP;
            valid <= 1'b0;
        end else if (load && !hold) begin
            instr <= fetch_instr;
            pc    <= fetch_pc;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection (branch > jump > halt > stall)
// and the IF/ID register feeding decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                 PC_W     = 16,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
    input  logic          Clock,
    input  logic          Reset,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic               halted;
    logic               halt_now;
    logic               flush;
    logic               hold;
    logic               load;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;
    logic               id_valid;

    // An older taken branch or a jump squashes a same-cycle halt request.
    always_comb begin
        halt_now = bus.HaltIn & ~halted & ~bus.BranchTaken & ~bus.Jump;
        flush    = bus.BranchTaken | bus.Jump | halt_now;
        hold     = ~flush & (halted | bus.Stall);
        load     = ~flush & ~hold;
    end

    always_comb begin
        pc_next = pc;
        if (bus.BranchTaken)
            pc_next = bus.BranchTarget & ~PC_W'(1);
        else if (bus.Jump)
            pc_next = bus.JumpTarget & ~PC_W'(1);
        else if (load)
            pc_next = pc + PC_W'(PC_STEP);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            pc <= pc_next;
            if (halt_now)
                halted <= 1'b1;
        end
    end

    if_id_register #(
        .PC_W (PC_W),
        .NOP  (NOP)
    ) u_if_id (
        .clk         (Clock),
        .rst         (Reset),
        .load        (load),
        .flush       (flush),
        .hold        (hold),
        .fetch_instr (bus.InstrData),
        .fetch_pc    (pc),
        .instr       (id_instr),
        .pc          (id_pc),
        .valid       (id_valid)
    );

    assign bus.InstrAddr    = pc;
    assign bus.Halted       = halted;
    assign bus.IfIdInstr    = id_instr;
    assign bus.IfIdPC       = id_pc;
    assign bus.IfIdValid    = id_valid;
    assign bus.Opcode       = id_instr[OP_HI:OP_LO];
    assign bus.FunctionCode = id_instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push the expected
// post-edge state, a monitor pops and compares one entry per clock.
module tb_fetch_stage;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
        logic        halted;
        logic        chk_pc;
    } exp_t;

    localparam logic [15:0] NOPW = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_W(16)) bus();

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000), .NOP(16'h0000)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Instruction memory: every address holds a distinct word.
    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    assign bus.InstrData = mem(bus.InstrAddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("InstrAddr", 32'(bus.InstrAddr), 32'(e.addr));
                chk("IfIdInstr", 32'(bus.IfIdInstr), 32'(e.instr));
                chk("IfIdValid", 32'(bus.IfIdValid), 32'(e.valid));
                chk("Halted", 32'(bus.Halted), 32'(e.halted));
                chk("Opcode", 32'(bus.Opcode), 32'(e.instr[15:12]));
                chk("FunctionCode", 32'(bus.FunctionCode), 32'(e.instr[3:0]));
                if (e.chk_pc)
                    chk("IfIdPC", 32'(bus.IfIdPC), 32'(e.pc));
            end
        end
    end

    // Called at a negedge: apply inputs, queue the state expected after the next posedge.
    task automatic step(input logic st, input logic br, input logic [15:0] bt,
                        input logic jp, input logic [15:0] jt, input logic hl,
                        input logic [15:0] e_addr, input logic [15:0] e_instr,
                        input logic [15:0] e_pc, input logic e_valid,
                        input logic e_halted, input logic e_chk_pc);
        exp_t e;
        bus.Stall        = st;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = jp;
        bus.JumpTarget   = jt;
        bus.HaltIn       = hl;
        e.addr   = e_addr;
        e.instr  = e_instr;
        e.pc     = e_pc;
        e.valid  = e_valid;
        e.halted = e_halted;
        e.chk_pc = e_chk_pc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] pc);
        step(0, 0, 16'h0, 0, 16'h0, 0, addr, mem(pc), pc, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic reset_now(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_addr"},   32'(bus.InstrAddr), 32'h0);
        chk({tag, "_instr"},  32'(bus.IfIdInstr), 32'(NOPW));
        chk({tag, "_pc"},     32'(bus.IfIdPC),    32'h0);
        chk({tag, "_valid"},  32'(bus.IfIdValid), 32'h0);
        chk({tag, "_halted"}, 32'(bus.Halted),    32'h0);
    endtask

    initial begin
        bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = '0;
        bus.Jump = 0; bus.JumpTarget = '0; bus.HaltIn = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Free run, then reset in the middle of it.
        fetch(16'h0002, 16'h0000);
        fetch(16'h0004, 16'h0002);
        fetch(16'h0006, 16'h0004);
        reset_now("rst_mid");
        step(0, 0, 16'h0, 0, 16'h0, 0, 16'h0000, NOPW, 16'h0000, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        fetch(16'h0002, 16'h0000);
        fetch(16'h0004, 16'h0002);
        fetch(16'h0006, 16'h0004);

        // Stall three cycles at PC=6, then resume.
        repeat (3) step(1, 0, 16'h0, 0, 16'h0, 0, 16'h0006, mem(16'h0004), 16'h0004, 1'b1, 1'b0, 1'b1);
        fetch(16'h0008, 16'h0006);

        // Jump to an odd target: bit 0 dropped, one bubble.
        step(0, 0, 16'h0, 1, 16'h0041, 0, 16'h0040, NOPW, 16'h0, 1'b0, 1'b0, 1'b0);
        fetch(16'h0042, 16'h0040);

        // Branch beats a same-cycle jump and stall.
        step(1, 1, 16'h0101, 1, 16'h0200, 0, 16'h0100, NOPW, 16'h0, 1'b0, 1'b0, 1'b0);
        fetch(16'h0102, 16'h0100);

        // Branch squashes a same-cycle halt.
        step(0, 1, 16'h0031, 0, 16'h0, 1, 16'h0030, NOPW, 16'h0, 1'b0, 1'b0, 1'b0);
        fetch(16'h0032, 16'h0030);

        // Halt (beats stall) then stay frozen for 10 cycles.
        step(1, 0, 16'h0, 0, 16'h0, 1, 16'h0032, NOPW, 16'h0, 1'b0, 1'b1, 1'b0);
        repeat (10) step(0, 0, 16'h0, 0, 16'h0, 0, 16'h0032, NOPW, 16'h0, 1'b0, 1'b1, 1'b0);

        // A jump still redirects while halted, but Halted stays set.
        step(0, 0, 16'h0, 1, 16'h0051, 0, 16'h0050, NOPW, 16'h0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 16'h0, 0, 16'h0, 0, 16'h0050, NOPW, 16'h0, 1'b0, 1'b1, 1'b0);

        // Only reset clears Halted.
        reset_now("rst_halt");
        @(negedge clk);
        rst = 1'b0;

        // PC wrap from FFFE to 0000.
        step(0, 0, 16'h0, 1, 16'hFFFF, 0, 16'hFFFE, NOPW, 16'h0, 1'b0, 1'b0, 1'b0);
        fetch(16'h0000, 16'hFFFE);
        fetch(16'h0002, 16'h0000);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
